jtag_tap_ctrl: RTL and testbench

- IEEE 1149.1 TAP controller that drives the team's chains of scan cells.
- Runs the 16-state TAP FSM on tck_i and holds the instruction register.
- Provides the BYPASS and IDCODE data registers internally.
- Generates the shift, capture and update controls for one external user scan chain, and muxes that chain's serial output onto tdo_o.

---
 rtl/jtag_tap_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_jtag_tap_ctrl.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl: IEEE 1149.1 TAP with IR, BYPASS, optional IDCODE and one user scan chain.
// Define JTAG_IDCODE_EN to build the 32-bit IDCODE register; IR then resets to IDCODE.
package jtag_tap_pkg;
    // Standard 1149.1 reference encoding.
    typedef enum logic [3:0] {
        EXIT2_DR         = 4'h0,
        EXIT1_DR         = 4'h1,
        SHIFT_DR         = 4'h2,
        PAUSE_DR         = 4'h3,
        SELECT_IR        = 4'h4,
        UPDATE_DR        = 4'h5,
        CAPTURE_DR       = 4'h6,
        SELECT_DR        = 4'h7,
        EXIT2_IR         = 4'h8,
        EXIT1_IR         = 4'h9,
        SHIFT_IR         = 4'hA,
        PAUSE_IR         = 4'hB,
        RUN_TEST_IDLE    = 4'hC,
        UPDATE_IR        = 4'hD,
        CAPTURE_IR       = 4'hE,
        TEST_LOGIC_RESET = 4'hF
    } tap_state_e;
endpackage

module jtag_tap_ctrl
    import jtag_tap_pkg::*;
#(
    parameter int                  IR_WIDTH   = 5,
    parameter logic [31:0]         IDCODE_VAL = 32'h1000_0001,
    parameter logic [IR_WIDTH-1:0] USER_INSTR = 5'h10
) (
    input  logic                tck_i,
    input  logic                trst_s,
    input  logic                tms_i,
    input  logic                tdi_i,
    output logic                tdo_o,
    output logic                tdo_en_o,
    output logic                user_sel_o,
    output logic                user_shift_o,
    output logic                user_capture_o,
    output logic                user_update_o,
    output logic                user_tdi_o,
    input  logic                user_tdo_i,
    output logic [IR_WIDTH-1:0] ir_o,
    output logic [3:0]          tap_state_o
);

    if (IR_WIDTH < 2) begin : g_bad_ir_width
        $error("jtag_tap_ctrl: IR_WIDTH must be >= 2");
    end
    if (IDCODE_VAL[0] != 1'b1) begin : g_bad_idcode
        $error("jtag_tap_ctrl: IDCODE_VAL bit 0 must be 1");
    end

    localparam logic [IR_WIDTH-1:0] IR_BYPASS  = '1;
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);
`ifdef JTAG_IDCODE_EN
    localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(1);
    localparam logic [IR_WIDTH-1:0] IR_RST     = IR_IDCODE;
`else
    localparam logic [IR_WIDTH-1:0] IR_RST     = IR_BYPASS;
`endif

    tap_state_e          state_q, state_d;
    logic [IR_WIDTH-1:0] ir_q;
    logic [IR_WIDTH-1:0] ir_sr_q;
    logic                byp_q;
    logic                tdo_q, tdo_d;
    logic                tdo_en_q;
    logic                sh_ir, sh_dr;
    logic                sel_user, sel_id, sel_byp;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TEST_LOGIC_RESET: state_d = tms_i ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    state_d = tms_i ? SELECT_DR  : RUN_TEST_IDLE;
            SELECT_DR:        state_d = tms_i ? SELECT_IR  : CAPTURE_DR;
            CAPTURE_DR:       state_d = tms_i ? EXIT1_DR   : SHIFT_DR;
            SHIFT_DR:         state_d = tms_i ? EXIT1_DR   : SHIFT_DR;
            EXIT1_DR:         state_d = tms_i ? UPDATE_DR  : PAUSE_DR;
            PAUSE_DR:         state_d = tms_i ? EXIT2_DR   : PAUSE_DR;
            EXIT2_DR:         state_d = tms_i ? UPDATE_DR  : SHIFT_DR;
            UPDATE_DR:        state_d = tms_i ? SELECT_DR  : RUN_TEST_IDLE;
            SELECT_IR:        state_d = tms_i ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       state_d = tms_i ? EXIT1_IR   : SHIFT_IR;
            SHIFT_IR:         state_d = tms_i ? EXIT1_IR   : SHIFT_IR;
            EXIT1_IR:         state_d = tms_i ? UPDATE_IR  : PAUSE_IR;
            PAUSE_IR:         state_d = tms_i ? EXIT2_IR   : PAUSE_IR;
            EXIT2_IR:         state_d = tms_i ? UPDATE_IR  : SHIFT_IR;
            UPDATE_IR:        state_d = tms_i ? SELECT_DR  : RUN_TEST_IDLE;
            default:          state_d = TEST_LOGIC_RESET;
        endcase
    end

    always_ff @(posedge tck_i or posedge trst_s) begin
        if (trst_s) begin
            state_q <= TEST_LOGIC_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    assign sh_ir    = (state_q == SHIFT_IR);
    assign sh_dr    = (state_q == SHIFT_DR);
    assign sel_user = (ir_q == USER_INSTR);
`ifdef JTAG_IDCODE_EN
    assign sel_id   = (ir_q == IR_IDCODE) && !sel_user;
`else
    assign sel_id   = 1'b0;
`endif
    assign sel_byp  = !sel_user && !sel_id;

    // IR reset is applied on the edge that enters TLR, so ir_o is valid there at once.
    always_ff @(posedge tck_i or posedge trst_s) begin
        if (trst_s) begin
            ir_q    <= IR_RST;
            ir_sr_q <= '0;
            byp_q   <= 1'b0;
        end else begin
            if (state_d == TEST_LOGIC_RESET) begin
                ir_q <= IR_RST;
            end else if (state_q == UPDATE_IR) begin
                ir_q <= ir_sr_q;
            end
            if (state_q == CAPTURE_IR) begin
                ir_sr_q <= IR_CAPTURE;
            end else if (sh_ir) begin
                ir_sr_q <= {tdi_i, ir_sr_q[IR_WIDTH-1:1]};
            end
            if (state_q == CAPTURE_DR) begin
                byp_q <= 1'b0;
            end else if (sh_dr) begin
                byp_q <= tdi_i;
            end
        end
    end

`ifdef JTAG_IDCODE_EN
    logic [31:0] dr_q;

    always_ff @(posedge tck_i or posedge trst_s) begin
        if (trst_s) begin
            dr_q <= '0;
        end else if (sel_id) begin
            if (state_q == CAPTURE_DR) begin
                dr_q <= IDCODE_VAL;
            end else if (sh_dr) begin
                dr_q <= {tdi_i, dr_q[31:1]};
            end
        end
    end
`endif

    always_comb begin
        tdo_d = tdo_q;
        unique case (1'b1)
            sh_ir:              tdo_d = ir_sr_q[0];
            sh_dr && sel_user:  tdo_d = user_tdo_i;
`ifdef JTAG_IDCODE_EN
            sh_dr && sel_id:    tdo_d = dr_q[0];
`endif
            sh_dr && sel_byp:   tdo_d = byp_q;
            default:            tdo_d = tdo_q;
        endcase
    end

    always_ff @(negedge tck_i or posedge trst_s) begin
        if (trst_s) begin
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else begin
            tdo_q    <= tdo_d;
            tdo_en_q <= sh_ir || sh_dr;
        end
    end

    assign tdo_o          = tdo_q;
    assign tdo_en_o       = tdo_en_q;
    assign user_sel_o     = sel_user;
    assign user_shift_o   = sel_user && sh_dr;
    assign user_capture_o = sel_user && (state_q == CAPTURE_DR);
    assign user_update_o  = sel_user && (state_q == UPDATE_DR);
    assign user_tdi_o     = tdi_i;
    assign ir_o           = ir_q;
    assign tap_state_o    = state_q;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// tb_jtag_tap_ctrl: drives TMS/TDI sequences and scoreboards tdo_o against
// expected bit streams, with an 8-cell user scan chain model on user_*.
`timescale 1ns/1ps
module tb_jtag_tap_ctrl;

    localparam logic [31:0] IDCODE = 32'h1000_0001;
`ifdef JTAG_IDCODE_EN
    localparam logic [4:0]  IR_RST = 5'h01;
`else
    localparam logic [4:0]  IR_RST = 5'h1F;
`endif

    logic       tck_i = 1'b0;
    logic       trst_s = 1'b0;
    logic       tms_i = 1'b1;
    logic       tdi_i = 1'b0;
    logic       tdo_o, tdo_en_o;
    logic       user_sel_o, user_shift_o, user_capture_o, user_update_o;
    logic       user_tdi_o, user_tdo_i;
    logic [4:0] ir_o;
    logic [3:0] tap_state_o;

    int checks = 0;
    int errors = 0;
    logic exp_q[$];
    logic exp_b;

    logic [7:0] cell_data = 8'hA5;
    logic [7:0] chain = 8'h00;
    logic [7:0] upd_reg = 8'h00;
    int shift_cnt = 0;
    int cap_cnt = 0;
    int upd_cnt = 0;

    jtag_tap_ctrl dut (
        .tck_i          (tck_i),
        .trst_s         (trst_s),
        .tms_i          (tms_i),
        .tdi_i          (tdi_i),
        .tdo_o          (tdo_o),
        .tdo_en_o       (tdo_en_o),
        .user_sel_o     (user_sel_o),
        .user_shift_o   (user_shift_o),
        .user_capture_o (user_capture_o),
        .user_update_o  (user_update_o),
        .user_tdi_o     (user_tdi_o),
        .user_tdo_i     (user_tdo_i),
        .ir_o           (ir_o),
        .tap_state_o    (tap_state_o)
    );

    initial forever #10 tck_i = ~tck_i;

    // Eight scan cells: capture parallel data, shift right, latch on update.
    always @(posedge tck_i) begin
        if (user_capture_o) chain <= cell_data;
        else if (user_shift_o) chain <= {user_tdi_o, chain[7:1]};
        if (user_update_o) upd_reg <= chain;
        if (user_shift_o) shift_cnt <= shift_cnt + 1;
        if (user_capture_o) cap_cnt <= cap_cnt + 1;
        if (user_update_o) upd_cnt <= upd_cnt + 1;
    end
    assign user_tdo_i = chain[0];

    task automatic tck_cycle(input logic tms, input logic tdi);
        tms_i = tms;
        tdi_i = tdi;
        @(posedge tck_i);
        @(negedge tck_i);
        #1;
    endtask

    task automatic load_ir(input logic [4:0] v);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tck_cycle(i == 4, v[i]);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
    endtask

    task automatic test_reset;
        @(negedge tck_i);
        #1;
        trst_s = 1'b1;
        #2;
        checks++;
        if (tap_state_o !== 4'hF) begin
            errors++;
            $display("FAIL rst_state: got %h expected %h", tap_state_o, 4'hF);
        end
        checks++;
        if (ir_o !== IR_RST) begin
            errors++;
            $display("FAIL rst_ir: got %h expected %h", ir_o, IR_RST);
        end
        checks++;
        if ({tdo_o, tdo_en_o} !== 2'b00) begin
            errors++;
            $display("FAIL rst_tdo: got %b%b expected 00", tdo_o, tdo_en_o);
        end
        checks++;
        if ({user_sel_o, user_shift_o, user_capture_o, user_update_o} !== 4'b0) begin
            errors++;
            $display("FAIL rst_user: got %b%b%b%b expected 0000", user_sel_o,
                     user_shift_o, user_capture_o, user_update_o);
        end
        tdi_i = 1'b1;
        #1;
        checks++;
        if (user_tdi_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_tdi_pass1: got %b expected 1", user_tdi_o);
        end
        tdi_i = 1'b0;
        #1;
        checks++;
        if (user_tdi_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_tdi_pass0: got %b expected 0", user_tdi_o);
        end
        trst_s = 1'b0;
    endtask

    task automatic test_idcode_read;
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0);
        checks++;
        if ({tap_state_o, tdo_en_o} !== {4'h2, 1'b1}) begin
            errors++;
            $display("FAIL id_shift_entry: got state %h en %b expected 2 1",
                     tap_state_o, tdo_en_o);
        end
        exp_q.delete();
`ifdef JTAG_IDCODE_EN
        for (int i = 0; i < 32; i++) exp_q.push_back(IDCODE[i]);
`else
        exp_q.push_back(1'b0);
`endif
        for (int i = 0; i < 32; i++) begin
            exp_b = exp_q.pop_front();
            checks++;
            if (tdo_o !== exp_b) begin
                errors++;
                $display("FAIL id_bit%0d: got %b expected %b", i, tdo_o, exp_b);
            end
`ifndef JTAG_IDCODE_EN
            exp_q.push_back(1'b0);
`endif
            tck_cycle(i == 31, 1'b0);
        end
        exp_q.delete();
        checks++;
        if ({tap_state_o, tdo_en_o} !== {4'h1, 1'b0}) begin
            errors++;
            $display("FAIL id_exit: got state %h en %b expected 1 0",
                     tap_state_o, tdo_en_o);
        end
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
    endtask

    task automatic test_ir_load;
        logic [4:0] v;
        v = 5'h10;
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0);
        checks++;
        if ({tap_state_o, tdo_en_o} !== {4'hA, 1'b1}) begin
            errors++;
            $display("FAIL ir_shift_entry: got state %h en %b expected a 1",
                     tap_state_o, tdo_en_o);
        end
        exp_q.delete();
        exp_q.push_back(1'b1);
        for (int i = 0; i < 4; i++) exp_q.push_back(1'b0);
        for (int i = 0; i < 5; i++) begin
            exp_b = exp_q.pop_front();
            checks++;
            if (tdo_o !== exp_b) begin
                errors++;
                $display("FAIL ir_cap_bit%0d: got %b expected %b", i, tdo_o, exp_b);
            end
            tck_cycle(i == 4, v[i]);
        end
        tck_cycle(1'b1, 1'b0);
        checks++;
        if (tap_state_o !== 4'hD) begin
            errors++;
            $display("FAIL ir_update_state: got %h expected d", tap_state_o);
        end
        tck_cycle(1'b0, 1'b0);
        checks++;
        if ({ir_o, user_sel_o} !== {5'h10, 1'b1}) begin
            errors++;
            $display("FAIL ir_loaded: got ir %h sel %b expected 10 1", ir_o, user_sel_o);
        end
    endtask

    task automatic test_user_chain;
        int s0, c0, u0;
        logic [7:0] pat;
        pat = 8'h3C;
        s0 = shift_cnt;
        c0 = cap_cnt;
        u0 = upd_cnt;
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        checks++;
        if (user_capture_o !== 1'b1) begin
            errors++;
            $display("FAIL usr_capture: got %b expected 1", user_capture_o);
        end
        tck_cycle(1'b0, 1'b0);
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(cell_data[i]);
        for (int i = 0; i < 8; i++) begin
            exp_b = exp_q.pop_front();
            checks++;
            if (tdo_o !== exp_b) begin
                errors++;
                $display("FAIL usr_tdo_bit%0d: got %b expected %b", i, tdo_o, exp_b);
            end
            tck_cycle(i == 3 || i == 7, pat[i]);
            if (i == 3) begin
                tck_cycle(1'b0, 1'b0);
                tck_cycle(1'b0, 1'b1);
                checks++;
                if ({tap_state_o, tdo_en_o, user_shift_o} !== {4'h3, 1'b0, 1'b0}) begin
                    errors++;
                    $display("FAIL usr_pause: got state %h en %b shift %b expected 3 0 0",
                             tap_state_o, tdo_en_o, user_shift_o);
                end
                tck_cycle(1'b1, 1'b1);
                tck_cycle(1'b0, 1'b0);
            end
        end
        tck_cycle(1'b1, 1'b0);
        checks++;
        if (user_update_o !== 1'b1) begin
            errors++;
            $display("FAIL usr_update_level: got %b expected 1", user_update_o);
        end
        tck_cycle(1'b0, 1'b0);
        checks++;
        if (shift_cnt - s0 !== 8) begin
            errors++;
            $display("FAIL usr_shift_count: got %0d expected 8", shift_cnt - s0);
        end
        checks++;
        if ((cap_cnt - c0 !== 1) || (upd_cnt - u0 !== 1)) begin
            errors++;
            $display("FAIL usr_cap_upd_count: got %0d/%0d expected 1/1",
                     cap_cnt - c0, upd_cnt - u0);
        end
        checks++;
        if ({chain, upd_reg} !== {pat, pat}) begin
            errors++;
            $display("FAIL usr_chain: got %h/%h expected %h", chain, upd_reg, pat);
        end
    endtask

    task automatic test_five_tms_reset;
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0);
        checks++;
        if (tap_state_o !== 4'h2) begin
            errors++;
            $display("FAIL tms5_entry: got %h expected 2", tap_state_o);
        end
        for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0);
        checks++;
        if ({tap_state_o, ir_o, user_sel_o} !== {4'hF, IR_RST, 1'b0}) begin
            errors++;
            $display("FAIL tms5_reset: got state %h ir %h sel %b expected f %h 0",
                     tap_state_o, ir_o, user_sel_o, IR_RST);
        end
    endtask

    task automatic test_bypass;
        logic [3:0] pat;
        pat = 4'b1101;
        tck_cycle(1'b0, 1'b0);
        load_ir(5'h1F);
        checks++;
        if (ir_o !== 5'h1F) begin
            errors++;
            $display("FAIL byp_ir: got %h expected 1f", ir_o);
        end
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0);
        exp_q.delete();
        exp_q.push_back(1'b0);
        for (int i = 0; i < 4; i++) begin
            exp_b = exp_q.pop_front();
            checks++;
            if (tdo_o !== exp_b) begin
                errors++;
                $display("FAIL byp_bit%0d: got %b expected %b", i, tdo_o, exp_b);
            end
            exp_q.push_back(pat[i]);
            tck_cycle(i == 3, pat[i]);
        end
        exp_q.delete();
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
    endtask

    task automatic test_async_reset_mid_shift;
        int u0;
        load_ir(5'h10);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b0, 1'b1);
        tck_cycle(1'b0, 1'b1);
        u0 = upd_cnt;
        #4;
        trst_s = 1'b1;
        #1;
        checks++;
        if ({tap_state_o, tdo_en_o, ir_o} !== {4'hF, 1'b0, IR_RST}) begin
            errors++;
            $display("FAIL arst_immediate: got state %h en %b ir %h expected f 0 %h",
                     tap_state_o, tdo_en_o, ir_o, IR_RST);
        end
        checks++;
        if ({user_sel_o, user_update_o} !== 2'b00) begin
            errors++;
            $display("FAIL arst_user: got sel %b upd %b expected 0 0",
                     user_sel_o, user_update_o);
        end
        #2;
        trst_s = 1'b0;
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        checks++;
        if ({tap_state_o, ir_o} !== {4'hC, IR_RST} || upd_cnt != u0) begin
            errors++;
            $display("FAIL arst_after: got state %h ir %h updates %0d expected c %h 0",
                     tap_state_o, ir_o, upd_cnt - u0, IR_RST);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #3;
        trst_s = 1'b1;
        #5;
        trst_s = 1'b0;
        test_reset();
        test_idcode_read();
        test_ir_load();
        test_user_chain();
        test_five_tms_reset();
        test_bypass();
        test_async_reset_mid_shift();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
